// File: rtl/destruct_pkg.sv
// Shared types and constants for the self-destruct sequencer.
// Contents:
//   state_t            FSM state encoding (IDLE=0, COUNT=1, DONE=2)
//   STATE_*            numeric values of the state encoding
//   DEF_*_TICKS        default tick constants for a 10 ms tick
package destruct_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_COUNT = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    COUNT = STATE_COUNT,
    DONE  = STATE_DONE
  } state_t;

  localparam int unsigned DEF_DEB_TICKS   = 3;
  localparam int unsigned DEF_STEP_TICKS  = 100;
  localparam int unsigned DEF_BLINK_TICKS = 33;

endpackage

// File: rtl/destruct_sequencer_debounce_ch.sv
// Single-channel tick-based debouncer.
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   tick   one-cycle base time strobe; the filter only advances on tick
//   raw    raw switch input
//   db     debounced value, flips after DEB_TICKS consecutive differing ticks
module debounce_ch #(
  parameter int unsigned DEB_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic db
);

  localparam int unsigned CntW = $clog2(DEB_TICKS + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      db    <= 1'b0;
      cnt_q <= '0;
    end else if (tick) begin
      if (raw != db) begin
        // Flip on the DEB_TICKS-th consecutive differing tick.
        if (cnt_q == CntW'(DEB_TICKS - 1)) begin
          db    <= ~db;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/destruct_sequencer.sv
// Robot self-destruct controller: debounces the fault and in-combat switches,
// votes K-of-N for danger and runs a blinking, pausable, abortable LED-bar
// countdown that ends in a sticky detonated state.
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   tick       one-cycle 10 ms strobe
//   in_combat  raw in-combat switch
//   fault_in   raw fault switches
//   abort      level abort request, sampled every clk
//   leds       registered LED bar
//   armed      high while counting down
//   detonated  high once the countdown completes, until reset
//   state      FSM state (IDLE=0, COUNT=1, DONE=2)
module destruct_sequencer
  import destruct_pkg::*;
#(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned VOTE_K      = 2,
  parameter int unsigned DEB_TICKS   = DEF_DEB_TICKS,
  parameter int unsigned STEP_TICKS  = DEF_STEP_TICKS,
  parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS,
  parameter int unsigned LED_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             in_combat,
  input  logic [N_IN-1:0]  fault_in,
  input  logic             abort,
  output logic [LED_W-1:0] leds,
  output logic             armed,
  output logic             detonated,
  output logic [1:0]       state
);

  localparam int unsigned CntW   = $clog2(N_IN + 1);
  localparam int unsigned StepW  = $clog2(STEP_TICKS + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_TICKS + 1);

  // Channel N_IN is in_combat, channels 0..N_IN-1 are the faults.
  logic [N_IN:0]   raw_all;
  logic [N_IN:0]   db_all;
  logic [N_IN-1:0] fault_db;
  logic            combat_db;

  assign raw_all   = {in_combat, fault_in};
  assign fault_db  = db_all[N_IN-1:0];
  assign combat_db = db_all[N_IN];

  for (genvar i = 0; i <= N_IN; i++) begin : g_deb
    debounce_ch #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (raw_all[i]),
      .db   (db_all[i])
    );
  end

  logic [CntW-1:0] fault_cnt;
  logic            danger;

  always_comb begin
    fault_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      fault_cnt = fault_cnt + CntW'(fault_db[i]);
    end
  end

  assign danger = (fault_cnt >= CntW'(VOTE_K));

  state_t              st_q, st_d;
  logic [LED_W-1:0]    bar_q, bar_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [BlinkW-1:0]   blink_q, blink_d;
  logic                vis_q, vis_d;
  logic [LED_W-1:0]    leds_d;

  always_comb begin
    st_d    = st_q;
    bar_d   = bar_q;
    step_d  = step_q;
    blink_d = blink_q;
    vis_d   = vis_q;

    unique case (st_q)
      IDLE: begin
        if (tick && combat_db && danger && !abort) begin
          st_d    = COUNT;
          bar_d   = '1;
          step_d  = '0;
          blink_d = '0;
          vis_d   = 1'b1;
        end
      end
      COUNT: begin
        // Abort acts on any clk and beats a final step on the same tick.
        if (abort || (tick && !combat_db)) begin
          st_d    = IDLE;
          bar_d   = '1;
          step_d  = '0;
          blink_d = '0;
          vis_d   = 1'b1;
        end else if (tick && danger) begin
          if (blink_q == BlinkW'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            vis_d   = ~vis_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
          if (step_q == StepW'(STEP_TICKS - 1)) begin
            step_d = '0;
            bar_d  = bar_q >> 1;
            if (bar_d == '0) begin
              st_d = DONE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        // !danger with combat: pause, everything holds.
      end
      DONE: begin
        st_d = DONE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  always_comb begin
    leds_d = '0;
    unique case (st_d)
      IDLE:    leds_d = combat_db ? bar_d : '0;
      COUNT:   leds_d = vis_d ? bar_d : '0;
      DONE:    leds_d = '1;
      default: leds_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q      <= IDLE;
      bar_q     <= '1;
      step_q    <= '0;
      blink_q   <= '0;
      vis_q     <= 1'b1;
      leds      <= '0;
      armed     <= 1'b0;
      detonated <= 1'b0;
    end else begin
      st_q      <= st_d;
      bar_q     <= bar_d;
      step_q    <= step_d;
      blink_q   <= blink_d;
      vis_q     <= vis_d;
      leds      <= leds_d;
      armed     <= (st_d == COUNT);
      detonated <= (st_d == DONE);
    end
  end

  assign state = st_q;

endmodule
